wb_dut: RTL and testbench
=========================

# wb_dut

Single-port Wishbone (B4 classic) registered bridge between a Wishbone master interface and a Wishbone slave interface. It sits between the master bus and the slave bus. It forwards each master cycle to the slave side with one register stage and returns the slave's termination to the master. It also rejects out-of-window addresses locally and terminates hung slave cycles with an error after a timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width, both sides
- DATA_WIDTH, 32, data width; SEL width is DATA_WIDTH/8
- BASE_ADDR, 32'h0000_0000, start of forwarded address window
- WINDOW_SIZE, 32'h0001_0000, window size in bytes; power of two, aligned to BASE_ADDR
- TIMEOUT, 256, cycles in REQ before local error termination; minimum 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m_cyc_i, m_stb_i, m_we_i  in  1 each  master-side cycle, strobe, write enable
- m_adr_i  in  ADDR_WIDTH  master address
- m_dat_i  in  DATA_WIDTH  master write data
- m_sel_i  in  DATA_WIDTH/8  byte selects
- m_dat_o  out  DATA_WIDTH  read data to master
- m_ack_o, m_err_o, m_rty_o  out  1 each  termination to master
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side cycle, strobe, write enable
- s_adr_o  out  ADDR_WIDTH  slave address
- s_dat_o  out  DATA_WIDTH  slave write data
- s_sel_o  out  DATA_WIDTH/8  slave byte selects
- s_dat_i  in  DATA_WIDTH  slave read data
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: on m_cyc_i&m_stb_i, latch adr/dat/sel/we.
  - If the address is in the window (BASE_ADDR ≤ adr < BASE_ADDR+WINDOW_SIZE), go to REQ.
  - Otherwise go to RESP with the error flag set; the slave side is untouched.
- REQ: s_cyc_o=s_stb_o=1, driven from latched registers. The timeout counter increments each cycle.
  - On any of s_ack_i/s_err_i/s_rty_i, capture s_dat_i (reads) and the flags, then go to RESP.
  - Priority when several are asserted: err > rty > ack.
  - Counter reaches TIMEOUT-1 with no termination: go to RESP with err.
  - m_cyc_i low while in REQ (master abort): go to IDLE and give no response.
- RESP: exactly one of m_ack_o/m_err_o/m_rty_o is high for exactly one cycle, then go to IDLE.
  - m_dat_o is valid with m_ack_o on reads. It holds its last value otherwise.
- The counter clears on entry to REQ.
- Writes return m_dat_o unchanged. Byte selects pass through unmodified.
- No internal registers are addressable; the block is transparent.

## Timing
- Reset (asynchronous assert): state IDLE. All outputs go to 0 immediately: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_ack_o, m_err_o, m_rty_o and m_dat_o.
- Reset mid-transaction aborts it with no termination. Deassertion is sampled synchronously.
- In-window latency: master request sampled at edge 0 → s_stb_o high after edge 1. Slave termination sampled at edge n → s_stb_o low and the m_* termination high after edge n+1 → m_* termination low after edge n+2.
  - Best case with a zero-wait slave: m_ack_o is high in the 3rd cycle after the request.
- Out-of-window: m_err_o high one cycle after the request is sampled; s_cyc_o stays 0.
- Timeout: m_err_o high TIMEOUT+1 cycles after the request is sampled.
- The master must hold stb and all request signals until it sees termination (classic handshake).
- A request still asserted in the RESP cycle is not re-accepted. It is sampled again in IDLE the following cycle.

## Structure
- Shared package wb_pkg: state enum (IDLE/REQ/RESP), termination-type enum, and the default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module, wb_timeout_cnt: a clearable counter with enable and an expired flag, parameterised by TIMEOUT.

## Test plan
- Write in window: adr=32'h0000_0010, dat=32'hDEAD_BEEF, sel=4'hF, slave acks in its first cycle → slave sees identical adr/dat/sel/we=1; m_ack_o is a single pulse 3 cycles after the request.
- Read in window: adr=32'h0000_0020, slave returns 32'h1234_5678 with ack after 3 wait states → m_dat_o=32'h1234_5678 with m_ack_o, 6 cycles after the request.
- Out of window: adr=32'h0002_0000 → m_err_o pulses after 1 cycle; s_cyc_o stays 0 throughout.
- Slave asserts err and ack in the same cycle → only m_err_o pulses; a later s_rty_i-only cycle → only m_rty_o pulses.
- Silent slave, TIMEOUT=16 → m_err_o pulses 17 cycles after the request; s_stb_o drops with it.
- Async reset asserted in REQ, plus a master abort (m_cyc_i low) in another transaction → all outputs 0 immediately on reset; abort gives no termination, and a following valid request completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the registered Wishbone bridge.
// Holds the FSM state encoding, the termination kinds and the default bus widths.
package wb_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    typedef enum logic [1:0] {
        TERM_NONE = 2'd0,
        TERM_ACK  = 2'd1,
        TERM_ERR  = 2'd2,
        TERM_RTY  = 2'd3
    } wb_term_e;

    // A slave may raise several terminations at once; err beats rty beats ack.
    function automatic wb_term_e resolve_term(input logic ack, input logic err, input logic rty);
        wb_term_e kind;
        kind = TERM_NONE;
        if (err) begin
            kind = TERM_ERR;
        end else if (rty) begin
            kind = TERM_RTY;
        end else if (ack) begin
            kind = TERM_ACK;
        end
        return kind;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Clearable, enabled up-counter that saturates at TIMEOUT-1 and flags it.
// Used to bound how long the bridge waits on a silent slave.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/wb_dut.sv
// Registered Wishbone B4 classic bridge: forwards in-window master cycles to the
// slave bus, rejects out-of-window addresses locally, and times out silent slaves.
module wb_dut
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] WINDOW_SIZE = ADDR_WIDTH'(32'h0001_0000),
    parameter int                    TIMEOUT     = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_cyc_i,
    input  logic                    m_stb_i,
    input  logic                    m_we_i,
    input  logic [ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [DATA_WIDTH-1:0]   m_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m_sel_i,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic                    m_ack_o,
    output logic                    m_err_o,
    output logic                    m_rty_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i
);

    localparam int SEL_W = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] RESP = ST_RESP;

    // Window is a power of two aligned to BASE_ADDR, so a mask compare suffices.
    localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~(WINDOW_SIZE - ADDR_WIDTH'(1));

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [1:0] term_reg;
    logic [1:0] term_next;

    logic       req_hit;
    logic       in_window;
    logic       slv_term;
    logic [1:0] slv_kind;
    logic       latch_en;
    logic       capture_en;
    logic       expired;

    assign req_hit   = m_cyc_i & m_stb_i;
    assign in_window = ((m_adr_i & WIN_MASK) == BASE_ADDR);
    // Only trust a termination while our strobe is actually presented.
    assign slv_term  = s_stb_o & (s_ack_i | s_err_i | s_rty_i);
    assign slv_kind  = resolve_term(s_ack_i, s_err_i, s_rty_i);

    assign latch_en   = (state_reg == IDLE) & req_hit & in_window;
    assign capture_en = (state_reg == REQ) & m_cyc_i & slv_term
                        & (slv_kind == TERM_ACK) & ~s_we_o;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_reg == IDLE),
        .en      (state_reg == REQ),
        .expired (expired)
    );

    always_comb begin
        state_next = state_reg;
        term_next  = term_reg;
        case (state_reg)
            IDLE: begin
                if (req_hit) begin
                    if (in_window) begin
                        state_next = REQ;
                        term_next  = TERM_NONE;
                    end else begin
                        state_next = RESP;
                        term_next  = TERM_ERR;
                    end
                end
            end
            REQ: begin
                if (!m_cyc_i) begin
                    state_next = IDLE;
                    term_next  = TERM_NONE;
                end else if (slv_term) begin
                    state_next = RESP;
                    term_next  = slv_kind;
                end else if (expired) begin
                    state_next = RESP;
                    term_next  = TERM_ERR;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                term_next  = TERM_NONE;
            end
        endcase
    end

    // All bus outputs are registered from the current state, adding one stage
    // between the FSM decision and what either bus sees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            term_reg  <= TERM_NONE;
            s_cyc_o   <= 1'b0;
            s_stb_o   <= 1'b0;
            s_we_o    <= 1'b0;
            s_adr_o   <= '0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            m_rty_o   <= 1'b0;
            m_dat_o   <= '0;
        end else begin
            state_reg <= state_next;
            term_reg  <= term_next;
            s_cyc_o   <= (state_reg == REQ);
            s_stb_o   <= (state_reg == REQ);
            m_ack_o   <= (state_reg == RESP) & (term_reg == TERM_ACK);
            m_err_o   <= (state_reg == RESP) & (term_reg == TERM_ERR);
            m_rty_o   <= (state_reg == RESP) & (term_reg == TERM_RTY);
            if (latch_en) begin
                s_adr_o <= m_adr_i;
                s_we_o  <= m_we_i;
            end
            if (capture_en) begin
                m_dat_o <= s_dat_i;
            end
        end
    end

    // Write data and byte selects are latched lane by lane, unmodified.
    genvar gi;
    generate
        for (gi = 0; gi < SEL_W; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_dat_o[8*gi +: 8] <= '0;
                    s_sel_o[gi]        <= 1'b0;
                end else if (latch_en) begin
                    s_dat_o[8*gi +: 8] <= m_dat_i[8*gi +: 8];
                    s_sel_o[gi]        <= m_sel_i[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_wb_dut.sv
// Scoreboard bench for wb_dut: directed master transactions push expected
// terminations; a monitor pops and compares whenever the bridge terminates.
module tb_wb_dut;
    import wb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_cyc_i, m_stb_i, m_we_i;
    logic [AW-1:0] m_adr_i;
    logic [DW-1:0] m_dat_i;
    logic [3:0]    m_sel_i;
    logic [DW-1:0] m_dat_o;
    logic          m_ack_o, m_err_o, m_rty_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [3:0]    s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i, s_err_i, s_rty_i;

    always #5 clk = ~clk;

    wb_dut #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BASE_ADDR   (32'h0000_0000),
        .WINDOW_SIZE (32'h0001_0000),
        .TIMEOUT     (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i)
    );

    typedef struct {
        logic [2:0]  term;      // {err, rty, ack}
        logic [31:0] data;
        int          req_edge;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Slave model configuration and expected slave-side request.
    bit          slv_en = 1'b0;
    int          slv_wait = 0;
    logic [2:0]  slv_term = 3'b000;
    logic [31:0] slv_rdata = '0;
    logic [31:0] exp_s_adr, exp_s_dat;
    logic [3:0]  exp_s_sel;
    logic        exp_s_we;
    string       cur_name = "";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: waits slv_wait strobe cycles, then terminates for exactly one cycle.
    initial begin : slave
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 1'b0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
            if (!(s_cyc_o && s_stb_o)) begin
                cnt  = 0;
                done = 1'b0;
            end else if (slv_en && !done) begin
                if (cnt == slv_wait) begin
                    {s_err_i, s_rty_i, s_ack_i} = slv_term;
                    s_dat_i = slv_rdata;
                    done = 1'b1;
                    chk({cur_name, "_s_adr"}, s_adr_o, exp_s_adr);
                    chk({cur_name, "_s_dat"}, s_dat_o, exp_s_dat);
                    chk({cur_name, "_s_sel"}, s_sel_o, exp_s_sel);
                    chk({cur_name, "_s_we"},  s_we_o,  exp_s_we);
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: every master-side termination must match the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (m_ack_o || m_err_o || m_rty_o) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_term: got err/rty/ack=%b%b%b expected none",
                             m_err_o, m_rty_o, m_ack_o);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_term"}, {m_err_o, m_rty_o, m_ack_o}, e.term);
                    chk({e.name, "_latency"}, edge_cnt - e.req_edge, e.lat);
                    chk({e.name, "_m_dat"}, m_dat_o, e.data);
                    chk({e.name, "_s_stb_low"}, s_stb_o, 0);
                end
            end
        end
    end

    task automatic xfer(input string name, input logic [31:0] adr, input logic we,
                        input logic [31:0] dat, input logic [3:0] sel, input bit fwd,
                        input bit s_en, input int s_wait, input logic [2:0] s_term,
                        input logic [31:0] rdata, input logic [2:0] exp_term,
                        input logic [31:0] exp_data, input int exp_lat);
        exp_t e;
        bit   got = 1'b0;
        bit   saw_cyc = 1'b0;
        @(negedge clk);
        cur_name  = name;
        slv_en    = s_en;
        slv_wait  = s_wait;
        slv_term  = s_term;
        slv_rdata = rdata;
        exp_s_adr = adr; exp_s_dat = dat; exp_s_sel = sel; exp_s_we = we;
        e.term = exp_term; e.data = exp_data; e.req_edge = edge_cnt + 1;
        e.lat = exp_lat; e.name = name;
        sb_q.push_back(e);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr; m_dat_i = dat; m_sel_i = sel;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk); #1;
            if (s_cyc_o) saw_cyc = 1'b1;
            if (m_ack_o || m_err_o || m_rty_o) got = 1'b1;
        end
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: got no termination within 64 cycles, expected one", name);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end
        chk({name, "_s_cyc_seen"}, saw_cyc, fwd);
    endtask

    initial begin : stim
        bit seen;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, m_ack_o, m_err_o, m_rty_o}, 0);
        chk("reset_s_adr", s_adr_o, 0);
        chk("reset_s_dat", s_dat_o, 0);
        chk("reset_m_dat", m_dat_o, 0);
        @(negedge clk) rst_n = 1'b1;

        //   name        adr           we  dat           sel  fwd en wt term    rdata         exp     exp_data      lat
        xfer("wr_ack",   32'h0000_0010, 1, 32'hDEAD_BEEF, 4'hF, 1, 1, 0, 3'b001, 32'h0,        3'b001, 32'h0,        3);
        xfer("rd_ws3",   32'h0000_0020, 0, 32'h0,        4'hF, 1, 1, 3, 3'b001, 32'h1234_5678, 3'b001, 32'h1234_5678, 6);
        xfer("oow_rd",   32'h0002_0000, 0, 32'h0,        4'hF, 0, 1, 0, 3'b001, 32'h0,        3'b100, 32'h1234_5678, 1);
        xfer("oow_edge", 32'h0001_0000, 1, 32'h5555_AAAA, 4'hF, 0, 1, 0, 3'b001, 32'h0,        3'b100, 32'h1234_5678, 1);
        xfer("rd_top",   32'h0000_FFFC, 0, 32'h0,        4'hF, 1, 1, 0, 3'b001, 32'h600D_CAFE, 3'b001, 32'h600D_CAFE, 3);
        xfer("err_ack",  32'h0000_0030, 1, 32'h0102_0304, 4'h3, 1, 1, 0, 3'b101, 32'hFFFF_FFFF, 3'b100, 32'h600D_CAFE, 3);
        xfer("rty_rd",   32'h0000_0040, 0, 32'h0,        4'hC, 1, 1, 1, 3'b010, 32'hEEEE_EEEE, 3'b010, 32'h600D_CAFE, 4);
        xfer("timeout",  32'h0000_0044, 0, 32'h0,        4'hF, 1, 0, 0, 3'b000, 32'h0,        3'b100, 32'h600D_CAFE, TO + 1);

        // Master abort: drop cyc mid-REQ, expect silence and an idle slave bus.
        @(negedge clk);
        slv_en = 1'b0;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0;
        m_adr_i = 32'h0000_0050; m_dat_i = '0; m_sel_i = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_s_stb_active", s_stb_o, 1);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_ack_o || m_err_o || m_rty_o) seen = 1'b1;
        end
        chk("abort_no_term", seen, 0);
        chk("abort_s_cyc_idle", s_cyc_o, 0);
        xfer("after_abort", 32'h0000_0054, 0, 32'h0, 4'hF, 1, 1, 0, 3'b001, 32'hA5A5_0F0F, 3'b001, 32'hA5A5_0F0F, 3);

        // Asynchronous reset in REQ: outputs clear between clock edges.
        @(negedge clk);
        slv_en = 1'b0;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1;
        m_adr_i = 32'h0000_0060; m_dat_i = 32'hCAFE_F00D; m_sel_i = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_s_stb_active", s_stb_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, m_ack_o, m_err_o, m_rty_o}, 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_s_dat", s_dat_o, 0);
        chk("rst_m_dat", m_dat_o, 0);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        xfer("after_rst", 32'h0000_0064, 0, 32'h0, 4'hF, 1, 1, 2, 3'b001, 32'h0BAD_F00D, 3'b001, 32'h0BAD_F00D, 5);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
